// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by fetch, decode and hazard logic.
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] count_q;

  // Count register: clears on reset, otherwise steps by one when enabled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= {CNT_W{1'b0}};
    end else if (i_en) begin
      count_q <= count_q + CNT_W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign o_count = count_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage: PC register, IF/ID pipeline register, run/halt FSM and
// performance counters, driven by the hazard unit's stall/flush controls.
module fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall_pc,
  input  logic             i_stall_if_id,
  input  logic             i_flush_if_id,
  input  logic [31:0]      i_branch_target,
  input  logic             i_halt,
  output logic [31:0]      o_imem_addr,
  input  logic [31:0]      i_imem_rdata,
  output logic [31:0]      o_if_id_pc,
  output logic [31:0]      o_if_id_instr,
  output logic             o_if_id_valid,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cnt_cycle,
  output logic [CNT_W-1:0] o_cnt_fetch,
  output logic [CNT_W-1:0] o_cnt_stall,
  output logic [CNT_W-1:0] o_cnt_flush
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic            run_s;
  logic            fetch_s;
  logic            unused_s;

  // State, PC and IF/ID registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0000_0000;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // Next-state logic: flush beats halt, halt beats the stalls.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_s       = 1'b0;
    case (state_q)
      RUN: begin
        if (i_flush_if_id) begin
          // Halt on a flushed cycle sits on the wrong path and is dropped.
          pc_d          = {i_branch_target[XLEN-1:2], 2'b00};
          if_id_pc_d    = 32'h0000_0000;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else if (i_halt) begin
          state_d       = HALTED;
          if_id_pc_d    = 32'h0000_0000;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else begin
          if (i_stall_pc) begin
            pc_d = pc_q;
          end else begin
            pc_d = pc_q + 32'd4;
          end
          if (i_stall_if_id) begin
            fetch_s = 1'b0;
          end else begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = i_imem_rdata;
            if_id_valid_d = 1'b1;
            fetch_s       = 1'b1;
          end
        end
      end
      HALTED: begin
        state_d       = HALTED;
        if_id_pc_d    = 32'h0000_0000;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end
      default: begin
        state_d       = HALTED;
        if_id_pc_d    = 32'h0000_0000;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end
    endcase
  end

  assign run_s    = (state_q == RUN);
  assign unused_s = ^i_branch_target[1:0];

  perf_counter #(.CNT_W(CNT_W)) u_cnt_cycle (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(run_s), .o_count(o_cnt_cycle)
  );
  perf_counter #(.CNT_W(CNT_W)) u_cnt_fetch (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(fetch_s), .o_count(o_cnt_fetch)
  );
  perf_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_en(run_s & i_stall_if_id & ~i_flush_if_id), .o_count(o_cnt_stall)
  );
  perf_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_en(run_s & i_flush_if_id), .o_count(o_cnt_flush)
  );

  assign o_imem_addr   = pc_q;
  assign o_if_id_pc    = if_id_pc_q;
  assign o_if_id_instr = if_id_instr_q;
  assign o_if_id_valid = if_id_valid_q;
  assign o_halted      = (state_q == HALTED);
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-side consumer of the pipeline stall/flush signals. Owns the PC register, the IF/ID pipeline register and a run/halt state machine. Reacts to the hazard detection unit's `o_stall_pc`, `o_stall_if_id` and `o_flush_if_id`, and to the branch target from the EX stage. Also maintains free-running performance counters used for IPC measurement.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_0000`: PC loaded on reset.
- `CNT_W`, `32`: width of each performance counter.

Ports:
- `i_clk`, input, 1: clock.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_stall_pc`, input, 1: hold PC (from hazard unit).
- `i_stall_if_id`, input, 1: hold IF/ID (from hazard unit).
- `i_flush_if_id`, input, 1: flush IF/ID and redirect PC (from hazard unit; asserted on branch taken).
- `i_branch_target`, input, 32: redirect address, valid when `i_flush_if_id`=1.
- `i_halt`, input, 1: ID-stage instruction is a halt (ebreak).
- `o_imem_addr`, output, 32: instruction memory address, equal to the current PC.
- `i_imem_rdata`, input, 32: asynchronous-read instruction word for `o_imem_addr`.
- `o_if_id_pc`, output, 32: PC of the instruction in ID.
- `o_if_id_instr`, output, 32: instruction in ID.
- `o_if_id_valid`, output, 1: 0 means the ID slot holds a bubble.
- `o_halted`, output, 1: state machine is in HALTED.
- `o_cnt_cycle`, output, CNT_W: cycles spent in RUN.
- `o_cnt_fetch`, output, CNT_W: valid instructions loaded into IF/ID.
- `o_cnt_stall`, output, CNT_W: cycles with `i_stall_if_id`=1 and no flush.
- `o_cnt_flush`, output, CNT_W: cycles with `i_flush_if_id`=1.

## Operation
- States: RUN and HALTED. Reset enters RUN.
- In RUN, update priority is reset > flush > halt > stall > normal.
- Flush:
  - `pc_q` <= `{i_branch_target[31:2], 2'b00}`.
  - IF/ID <= bubble: valid=0, instr=NOP (`32'h0000_0013`), pc=0.
  - Flush overrides `i_stall_pc` and `i_stall_if_id`.
  - `i_halt` is ignored because the halting instruction is on the wrong path.
- Halt (RUN, `i_halt`=1, no flush):
  - Next state is HALTED.
  - PC is held.
  - IF/ID <= bubble.
- Stall, with no flush or halt:
  - `i_stall_pc`=1 holds `pc_q`.
  - `i_stall_if_id`=1 holds the IF/ID contents.
  - The two stall inputs act independently.
- Normal:
  - `pc_q` <= `pc_q + 4`, 32-bit wrap.
  - IF/ID <= `{pc_q, i_imem_rdata, 1}`.
- HALTED:
  - PC is frozen and IF/ID holds a bubble.
  - All inputs except `i_reset` are ignored.
  - The only exit is reset.
- Counters:
  - Increment only in RUN.
  - Wrap at 2^CNT_W.
  - `o_cnt_fetch` increments when IF/ID loads with valid=1.
- Reset values:
  - `pc_q` = RESET_PC.
  - IF/ID = bubble (valid 0, instr NOP, pc 0).
  - `o_halted` = 0.
  - All counters = 0.
  - `o_imem_addr` = RESET_PC.

## Timing
- `o_imem_addr` is a combinational copy of `pc_q`.
- All other outputs are registered.
- The instruction at PC = A appears on `o_if_id_*` one cycle after A is presented on `o_imem_addr`, unless that cycle is stalled or flushed.
- Redirect latency:
  - Flush asserted in cycle N: `o_imem_addr` = target in N+1.
  - The target instruction is valid in ID in N+2.
  - `o_if_id_valid`=0 in N+1.
- Stall on consecutive cycles: `o_if_id_*` stays bit-identical for every stalled cycle.
- Reset asserted mid-stall or mid-flush: reset wins that cycle, and RUN at RESET_PC resumes the next cycle.
- Halt asserted in cycle N: `o_halted`=1 from N+1, and `o_cnt_cycle` stops counting from N+1.

## Structure
- `pipeline_pkg` holds:
  - `XLEN`=32.
  - `NOP_INSTR`=`32'h0000_0013`.
  - `fetch_state_e` (RUN, HALTED).
- `pipeline_pkg` is shared with the decode and hazard logic.
- One sub-module, `perf_counter`:
  - Parameter CNT_W.
  - Ports `i_clk`, `i_reset`, `i_en`, `o_count`.
  - Instantiated four times.
- The PC, IF/ID register and FSM stay in `fetch_ctrl`.

## Test plan
- Reset release, with imem returning `32'h0010_0093` at PC 0:
  - `o_imem_addr` reads 0, then 4.
  - Next cycle: `o_if_id_instr`=`32'h0010_0093`, `o_if_id_pc`=0, `o_if_id_valid`=1.
- Stall on both inputs for 3 cycles at PC 8:
  - `o_imem_addr` stays 8 and IF/ID stays unchanged.
  - `o_cnt_stall` increases by 3.
  - Resuming loads PC 8's instruction.
- Flush with target `32'h0000_0102` while stalls are also asserted:
  - Next `o_imem_addr`=`32'h100`.
  - `o_if_id_valid`=0; stalls are ignored.
  - `o_cnt_flush` increases by 1.
- Halt with no flush:
  - `o_halted`=1 next cycle.
  - PC is frozen and IF/ID holds a bubble.
  - `o_cnt_cycle` stops.
  - Later flush or stall inputs have no effect.
- Halt and flush in the same cycle: flush is applied and `o_halted` stays 0.
- Reset asserted while HALTED with counters nonzero: the next cycle is RUN, PC = RESET_PC, all counters = 0.
